if_id_skid_reg: RTL and testbench

//  Parametrised IF->ID pipeline register with valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_entry_reg.sv | 24 ++
 rtl/if_id_skid_reg.sv | 128 ++++++++++++
 tb/tb_if_id_skid_reg.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the IF->ID skid register: FSM states, default NOP word and payload layout.
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2, SLOT_WAIT = 2'd3} state_e;

  localparam int PC_W_DEF    = 32;
  localparam int INSTR_W_DEF = 32;
  localparam logic [INSTR_W_DEF-1:0] NOP_DEF = '0;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } entry_t;
endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline slot: valid bit plus payload; load wins over clear, payload holds on clear.
module pipe_entry_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline register with 2-entry skid buffer, redirect squash and trap flush.
// Optional delay-slot retention on redirect when IF_ID_DELAY_SLOT_EN is defined.
module if_id_skid_reg
  import pipe_pkg::*;
#(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_DEF),
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [PC_W-1:0]    if_pc,
  input  logic [INSTR_W-1:0] if_instr,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [PC_W-1:0]    id_pc,
  output logic [INSTR_W-1:0] id_instr,
  input  logic               redirect,
  input  logic               flush,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   squash_cnt
);
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } pl_t;

  pl_t        if_pl, out_q, skid_q, out_d;
  logic       out_v, skid_v;
  logic       out_load, out_clr, out_sel_skid, skid_load, skid_clr;
  logic       acc, deq;
  logic [1:0] sq;
  state_e     state, nxt;
  logic [CNT_W:0] cnt_sum;

  assign if_pl = '{pc: if_pc, instr: if_instr};
  assign acc   = if_valid & if_ready;
  assign deq   = out_v & id_ready;
  assign out_d = out_sel_skid ? skid_q : if_pl;

  pipe_entry_reg #(.W($bits(pl_t))) u_out (
    .clk, .rst_n, .load(out_load), .clear(out_clr), .d(out_d), .valid(out_v), .q(out_q)
  );
  pipe_entry_reg #(.W($bits(pl_t))) u_skid (
    .clk, .rst_n, .load(skid_load), .clear(skid_clr), .d(if_pl), .valid(skid_v), .q(skid_q)
  );

  always_comb begin
    out_load     = 1'b0;
    out_clr      = 1'b0;
    out_sel_skid = 1'b0;
    skid_load    = 1'b0;
    skid_clr     = 1'b0;
    sq           = 2'd0;
    nxt          = state;
    if (flush) begin
      out_clr  = 1'b1;
      skid_clr = 1'b1;
      sq       = {1'b0, out_v} + {1'b0, skid_v} + {1'b0, acc};
      nxt      = EMPTY;
    end else if (redirect && deq) begin
`ifdef IF_ID_DELAY_SLOT_EN
      // Oldest younger word survives as the delay slot; acc cannot coexist with a valid SKID.
      if (skid_v) begin
        out_load     = 1'b1;
        out_sel_skid = 1'b1;
        skid_clr     = 1'b1;
        nxt          = HALF;
      end else if (acc) begin
        out_load = 1'b1;
        nxt      = HALF;
      end else begin
        out_clr = 1'b1;
        nxt     = SLOT_WAIT;
      end
`else
      out_clr  = 1'b1;
      skid_clr = 1'b1;
      sq       = {1'b0, skid_v} + {1'b0, acc};
      nxt      = EMPTY;
`endif
    end else begin
      case (state)
        EMPTY: if (acc) begin out_load = 1'b1; nxt = HALF; end
        HALF: begin
          if (acc && deq) out_load = 1'b1;
          else if (acc) begin skid_load = 1'b1; nxt = FULL; end
          else if (deq) begin out_clr = 1'b1; nxt = EMPTY; end
        end
        FULL: if (deq) begin
          out_load     = 1'b1;
          out_sel_skid = 1'b1;
          skid_clr     = 1'b1;
          nxt          = HALF;
        end
`ifdef IF_ID_DELAY_SLOT_EN
        SLOT_WAIT: if (acc) begin out_load = 1'b1; nxt = HALF; end
`endif
        default: nxt = EMPTY;
      endcase
    end
  end

  assign cnt_sum = {1'b0, squash_cnt} + (CNT_W+1)'(sq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      squash_cnt <= '0;
    end else begin
      state      <= nxt;
      squash_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

  assign id_valid  = out_v;
  assign id_pc     = out_q.pc;
  assign id_instr  = out_v ? out_q.instr : NOP_INSTR;
  assign if_ready  = ~skid_v;
  assign occupancy = {1'b0, out_v} + {1'b0, skid_v};

  // A redirect must come from the branch leaving ID this cycle.
  redirect_needs_deq: assert property (@(posedge clk) disable iff (!rst_n)
    (redirect && !flush) |-> deq);
endmodule

// File: tb/tb_if_id_skid_reg.sv
// Randomized + directed bench for if_id_skid_reg against a queue-based reference model.
module tb_if_id_skid_reg;
  localparam int PC_W = 32, IW = 32, CW = 6;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [IW-1:0] NOP = 32'h0000_0013;

  logic clk, rst_n;
  logic if_valid, if_ready, id_valid, id_ready, redirect, flush;
  logic [PC_W-1:0] if_pc, id_pc;
  logic [IW-1:0] if_instr, id_instr;
  logic [1:0] occupancy;
  logic [CW-1:0] squash_cnt;

  if_id_skid_reg #(.PC_W(PC_W), .INSTR_W(IW), .NOP_INSTR(NOP), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_instr(if_instr), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_instr(id_instr), .redirect(redirect), .flush(flush), .occupancy(occupancy),
    .squash_cnt(squash_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: FIFO of in-flight words (head = word in ID), plus squash total.
  logic [63:0] mq[$];
  logic [63:0] younger[$];
  int mcnt, msq;
  bit macc, mdeq;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mcnt = 0;
    end else begin
      macc = if_valid && mq.size() < 2;
      mdeq = mq.size() > 0 && id_ready;
      msq  = 0;
      if (flush) begin
        msq = mq.size() + int'(macc);
        mq.delete();
      end else if (redirect && mdeq) begin
        void'(mq.pop_front());
        younger = mq;
        if (macc) younger.push_back({if_pc, if_instr});
        mq.delete();
`ifdef IF_ID_DELAY_SLOT_EN
        if (younger.size() > 0) begin
          mq.push_back(younger[0]);
          msq = younger.size() - 1;
        end
`else
        msq = younger.size();
`endif
      end else begin
        if (mdeq) void'(mq.pop_front());
        if (macc) mq.push_back({if_pc, if_instr});
      end
      mcnt = (mcnt + msq > CMAX) ? CMAX : mcnt + msq;
    end
  end

  always @(negedge clk) begin
    chk("m_id_valid", id_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("m_id_pc", id_pc, mq[0][63:32]);
      chk("m_id_instr", id_instr, mq[0][31:0]);
    end else chk("m_id_nop", id_instr, NOP);
    chk("m_if_ready", if_ready, mq.size() < 2);
    chk("m_occupancy", occupancy, mq.size());
    chk("m_squash_cnt", squash_cnt, mcnt);
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drv(bit v, logic [31:0] pc, bit rdy, bit rd, bit fl);
    if_valid = v;
    if_pc    = pc;
    if_instr = pc ^ 32'hA5A5_0000;
    id_ready = rdy;
    redirect = rd;
    flush    = fl;
  endtask

  task automatic reset_pulse(string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_valid"}, id_valid, 0);
    chk({tag, "_occ"}, occupancy, 0);
    chk({tag, "_ready"}, if_ready, 1);
    chk({tag, "_cnt"}, squash_cnt, 0);
    chk({tag, "_instr"}, id_instr, NOP);
    chk({tag, "_pc"}, id_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit rdy;
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0);
    repeat (2) cyc();
    chk("rst_valid", id_valid, 0);
    chk("rst_ready", if_ready, 1);
    chk("rst_pc", id_pc, 0);
    chk("rst_instr", id_instr, NOP);
    chk("rst_occ", occupancy, 0);
    chk("rst_cnt", squash_cnt, 0);
    rst_n = 1'b1;

    // 1: single-cycle latency, one word per cycle
    drv(1, 32'h100, 1, 0, 0); cyc();
    chk("t1_valid", id_valid, 1); chk("t1_pc0", id_pc, 32'h100);
    drv(1, 32'h104, 1, 0, 0); cyc(); chk("t1_pc1", id_pc, 32'h104);
    drv(1, 32'h108, 1, 0, 0); cyc(); chk("t1_pc2", id_pc, 32'h108);
    drv(0, 0, 1, 0, 0); cyc(); chk("t1_empty", id_valid, 0);

    // 2: stall fills the skid, then in-order drain
    drv(1, 32'h100, 1, 0, 0); cyc();
    drv(1, 32'h104, 0, 0, 0); cyc();
    chk("t2_occ2", occupancy, 2); chk("t2_rdy0", if_ready, 0); chk("t2_hold", id_pc, 32'h100);
    drv(1, 32'h108, 0, 0, 0); cyc();
    chk("t2_occ2b", occupancy, 2); chk("t2_stable", id_pc, 32'h100);
    drv(1, 32'h108, 1, 0, 0); cyc();
    chk("t2_pc104", id_pc, 32'h104); chk("t2_occ1", occupancy, 1);
    cyc();
    chk("t2_pc108", id_pc, 32'h108); chk("t2_occ1b", occupancy, 1);

    // 3: flush of a full buffer under stall
    drv(1, 32'h10C, 0, 0, 0); cyc(); chk("t3_full", occupancy, 2);
    drv(0, 0, 0, 0, 1); cyc();
    chk("t3_valid", id_valid, 0); chk("t3_nop", id_instr, NOP);
    chk("t3_occ", occupancy, 0); chk("t3_cnt", squash_cnt, 2);

    // 4/5: redirect from FULL (fetch blocked), then from HALF with an accepted beat
    drv(1, 32'h200, 0, 0, 0); cyc();
    drv(1, 32'h204, 0, 0, 0); cyc();
    drv(1, 32'h208, 1, 1, 0); cyc();
`ifdef IF_ID_DELAY_SLOT_EN
    chk("t5_slot_valid", id_valid, 1); chk("t5_slot_pc", id_pc, 32'h204);
    chk("t5_cnt", squash_cnt, 2);
`else
    chk("t4_valid", id_valid, 0); chk("t4_cnt", squash_cnt, 3);
`endif
    drv(0, 0, 1, 0, 0); cyc(); chk("t4_drain", id_valid, 0);
    drv(1, 32'h300, 1, 0, 0); cyc();
    drv(1, 32'h304, 1, 1, 0); cyc();
`ifdef IF_ID_DELAY_SLOT_EN
    chk("t5_acc_pc", id_pc, 32'h304); chk("t5_acc_cnt", squash_cnt, 2);
`else
    chk("t4_acc_valid", id_valid, 0); chk("t4_acc_cnt", squash_cnt, 4);
`endif
    drv(0, 0, 1, 0, 0); cyc();
    // nothing younger: delay-slot build waits for the next beat
    drv(1, 32'h400, 1, 0, 0); cyc();
    drv(0, 0, 1, 1, 0); cyc(); chk("t5_wait_valid", id_valid, 0);
    drv(0, 0, 1, 0, 0); cyc(); chk("t5_wait_idle", id_valid, 0);
    drv(1, 32'h408, 1, 0, 0); cyc(); chk("t5_wait_pc", id_pc, 32'h408);
    drv(0, 0, 1, 1, 0); cyc();
    drv(1, 32'h40C, 0, 0, 1); cyc();
    chk("t5_wflush_valid", id_valid, 0);
`ifdef IF_ID_DELAY_SLOT_EN
    chk("t5_wflush_cnt", squash_cnt, 3);
`else
    chk("t4_wflush_cnt", squash_cnt, 5);
`endif
    drv(1, 32'h410, 1, 0, 0); cyc(); chk("t5_resume", id_pc, 32'h410);

    // 6: reset mid-stream, then saturation of the squash counter
    drv(1, 32'h500, 0, 0, 0); cyc();
    drv(1, 32'h504, 0, 0, 0); cyc();
    reset_pulse("t6_rst");
    for (int i = 0; i < 32; i++) begin
      drv(1, 32'h600 + 8 * i, 0, 0, 0); cyc();
      drv(1, 32'h604 + 8 * i, 0, 0, 0); cyc();
      drv(0, 0, 0, 0, 1); cyc();
      if (i == 30) chk("t6_cnt62", squash_cnt, 62);
    end
    chk("t6_sat", squash_cnt, CMAX);

    // randomized traffic against the model
    reset_pulse("rnd_rst0");
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) reset_pulse("rnd_rst1");
      rdy = ($urandom % 3) != 0;
      drv(($urandom % 4) != 0, $urandom, rdy,
          (mq.size() > 0) && rdy && (($urandom % 6) == 0), ($urandom % 16) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
